counter_updown: RTL and testbench

Parametrised up/down counter generalising the basic free-running counter: configurable width and modulo limit, count enable, direction control, synchronous load and clear, run-time selectable wrap or saturate behaviour, a terminal-count pulse and a sticky overflow flag. It serves as the general counting primitive for timers, address generators and event counters in the design. An optional compile-time prescaler divides the enable rate.

---
 rtl/counter_pkg.sv | 10 +
 rtl/counter_prescaler.sv | 31 +++
 rtl/counter_updown.sv | 95 +++++++++
 tb/tb_counter_updown.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the counter family: direction and boundary-mode encodings.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Enable-rate divider: tick_o fires on every PRESCALE-th en_i cycle.
// Instantiated by counter_updown only when COUNTER_UPDOWN_PRESCALER_EN is defined.
module counter_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  // Keep at least one bit so PRESCALE=1 still elaborates (the counter then sits at 0).
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
    end else if (clr_i) begin
      pre_q <= '0;
    end else if (en_i) begin
      pre_q <= (pre_q == LAST) ? '0 : pre_q + PW'(1);
    end
  end

  assign tick_o = en_i && (pre_q == LAST);

endmodule

// File: rtl/counter_updown.sv
// Parametrised up/down counter with load, clear, wrap/saturate, tc pulse and sticky overflow.
// Optional enable prescaler compiled in with COUNTER_UPDOWN_PRESCALER_EN.
module counter_updown
  import counter_pkg::*;
#(
  parameter int unsigned BW       = 8,
  parameter int unsigned MAX      = 2**BW - 1,
  parameter int unsigned PRESCALE = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          up_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [BW-1:0] load_val_i,
  input  logic          sat_i,
  output logic [BW-1:0] count_o,
  output logic          tc_o,
  output logic          ovf_o
);

  localparam logic [BW-1:0] MAX_V = BW'(MAX);

  if ((BW < 2) || (MAX < 1) || (MAX > 2**BW - 1) || (PRESCALE < 1)) begin : g_param_check
    $error("counter_updown: illegal BW/MAX/PRESCALE combination");
  end

  logic          step;
  logic [BW-1:0] count_q, count_d;
  logic          tc_q, tc_d;
  logic          ovf_q, ovf_d;

`ifdef COUNTER_UPDOWN_PRESCALER_EN
  // Load also restarts the prescaler so a fresh value gets a full division period.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .clr_i  (clr_i | load_i),
    .tick_o (step)
  );
`else
  assign step = en_i;
`endif

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      count_d = (load_val_i > MAX_V) ? MAX_V : load_val_i;
    end else if (step) begin
      if (up_i == DIR_UP) begin
        if (count_q == MAX_V) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (sat_i == MODE_SAT) ? MAX_V : '0;
        end else begin
          count_d = count_q + BW'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (sat_i == MODE_WRAP) ? MAX_V : '0;
        end else begin
          count_d = count_q - BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_counter_updown.sv
// Directed + random bench for counter_updown (BW=4, MAX=9, PRESCALE=3) against an arithmetic model.
module tb_counter_updown;

  localparam int BW = 4;
  localparam int MAX = 9;
  localparam int PRESCALE = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0, up_i = 1'b1, clr_i = 1'b0, load_i = 1'b0, sat_i = 1'b0;
  logic [BW-1:0] load_val_i = '0;
  logic [BW-1:0] count_o;
  logic          tc_o, ovf_o;

  int checks = 0;
  int errors = 0;

  // Reference state
  int m_cnt = 0;
  int m_pre = 0;
  bit m_tc = 0;
  bit m_ovf = 0;

  always #5 clk_i = ~clk_i;

  counter_updown #(.BW(BW), .MAX(MAX), .PRESCALE(PRESCALE)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .up_i       (up_i),
    .clr_i      (clr_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .sat_i      (sat_i),
    .count_o    (count_o),
    .tc_o       (tc_o),
    .ovf_o      (ovf_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, int'(count_o), m_cnt);
    chk({tag, ".tc"}, int'(tc_o), int'(m_tc));
    chk({tag, ".ovf"}, int'(ovf_o), int'(m_ovf));
  endtask

  // Boundary = step would leave 0..MAX; wrap is modulo MAX+1, saturate keeps the value.
  task automatic model_edge();
    int nxt;
    bit stepping;
    if (clr_i) begin
      m_cnt = 0; m_tc = 0; m_ovf = 0; m_pre = 0;
    end else if (load_i) begin
      m_cnt = (int'(load_val_i) > MAX) ? MAX : int'(load_val_i);
      m_tc = 0; m_pre = 0;
    end else begin
      m_tc = 0;
      stepping = 0;
      if (en_i) begin
`ifdef COUNTER_UPDOWN_PRESCALER_EN
        m_pre = m_pre + 1;
        if (m_pre == PRESCALE) begin
          stepping = 1;
          m_pre = 0;
        end
`else
        stepping = 1;
`endif
      end
      if (stepping) begin
        nxt = m_cnt + (up_i ? 1 : -1);
        if (nxt < 0 || nxt > MAX) begin
          m_tc = 1;
          m_ovf = 1;
          nxt = sat_i ? m_cnt : (nxt + MAX + 1) % (MAX + 1);
        end
        m_cnt = nxt;
      end
    end
  endtask

  task automatic cyc(input string tag, input logic e, input logic u, input logic c,
                     input logic l, input logic s, input logic [BW-1:0] v);
    en_i = e; up_i = u; clr_i = c; load_i = l; sat_i = s; load_val_i = v;
    @(posedge clk_i);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  initial begin
    // Reset state
    #2;
    chk_all("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Up wrap from 0
    for (int i = 0; i < 10; i++) cyc("up_wrap", 1, 1, 0, 0, 0, '0);
`ifndef COUNTER_UPDOWN_PRESCALER_EN
    chk("up_wrap.final_count", int'(count_o), 0);
    chk("up_wrap.final_tc", int'(tc_o), 1);
`endif
    chk("up_wrap.ovf", int'(ovf_o), int'(m_ovf));

    // Asynchronous reset mid-cycle with ovf set and count at 5
    cyc("load5", 0, 1, 0, 1, 0, 4'd5);
    #2;
    rst_ni = 1'b0;
    #1;
    m_cnt = 0; m_tc = 0; m_ovf = 0; m_pre = 0;
    chk_all("async_rst");
    @(posedge clk_i);
    #1;
    chk_all("rst_held");
    #3;
    rst_ni = 1'b1;

    // Down saturate from 2
    cyc("down_sat.load", 0, 0, 0, 1, 1, 4'd2);
    for (int i = 0; i < 4; i++) cyc("down_sat", 1, 0, 0, 0, 1, '0);
`ifndef COUNTER_UPDOWN_PRESCALER_EN
    chk("down_sat.final_count", int'(count_o), 0);
    chk("down_sat.final_tc", int'(tc_o), 1);
    chk("down_sat.ovf", int'(ovf_o), 1);
`endif

    // Load clamp, clear beats load, enable-low hold
    cyc("load_clamp", 0, 1, 0, 1, 0, 4'd15);
    chk("load_clamp.nine", int'(count_o), 9);
    cyc("clr_over_load", 0, 1, 1, 1, 0, 4'd7);
    chk("clr_over_load.zero", int'(count_o), 0);
    for (int i = 0; i < 5; i++) cyc("en_low_hold", 0, 1, 0, 0, 0, '0);

    // Direction flip at MAX in wrap mode
    cyc("flip.load", 0, 1, 0, 1, 0, 4'd9);
`ifndef COUNTER_UPDOWN_PRESCALER_EN
    cyc("flip.up", 1, 1, 0, 0, 0, '0);
    chk("flip.up_zero", int'(count_o), 0);
    cyc("flip.down", 1, 0, 0, 0, 0, '0);
    chk("flip.down_nine", int'(count_o), 9);
    chk("flip.down_tc", int'(tc_o), 1);
`else
    // Prescaler: step on every 3rd enabled cycle, holds while en_i is low
    cyc("pre.clr", 0, 1, 1, 0, 0, '0);
    for (int i = 0; i < 9; i++) cyc("pre.run", 1, 1, 0, 0, 0, '0);
    chk("pre.run_final", int'(count_o), 3);
    cyc("pre.clr2", 0, 1, 1, 0, 0, '0);
    for (int i = 0; i < 2; i++) cyc("pre.part", 1, 1, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) cyc("pre.pause", 0, 1, 0, 0, 0, '0);
    cyc("pre.resume", 1, 1, 0, 0, 0, '0);
    chk("pre.resume_step", int'(count_o), 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 31) == 0),
          logic'($urandom_range(0, 15) == 0),
          logic'($urandom_range(0, 1)),
          BW'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
